ps2_data_in: RTL and testbench
==============================

Name: ps2_data_in

Overview:
- Device-to-host PS/2 frame receiver. It is the receive-side companion to the host-to-device command transmitter in the PS/2 core.
- Consumes the same synchronised clock-edge strobes and synchronised data line, deserialises 11-bit frames, checks odd parity and the stop bit, and presents received bytes to the register/FIFO layer.
- The core's top level inhibits it while the transmitter owns the bus.

Parameters:
- CLOCK_CYCLES_FOR_2MS, 200000: frame timeout in clk cycles (100 MHz system clock).
- NUMBER_OF_BITS_FOR_2MS, 18: width of the timeout counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- receive_enable  in  1  high = receiver may accept frames; low = abort and hold idle
- ps2_clk_posedge  in  1  one-cycle strobe, PS/2 clock rising edge (already synchronised)
- ps2_clk_negedge  in  1  one-cycle strobe, PS/2 clock falling edge (already synchronised)
- ps2_data  in  1  synchronised PS/2 data line level
- received_data  out  8  last good byte
- received_data_en  out  1  one-cycle pulse, received_data updated
- error_parity  out  1  one-cycle pulse, parity mismatch
- error_framing  out  1  one-cycle pulse, stop bit was 0
- error_timeout  out  1  one-cycle pulse, frame not completed within 2 ms
- busy  out  1  high from start bit detection until frame end or abort

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; all outputs 0; shift register, bit counter and timeout counter cleared.
- States: IDLE, WAIT_FOR_START, DATA_IN, PARITY_IN, STOP_IN.
- IDLE -> WAIT_FOR_START when receive_enable = 1.
- WAIT_FOR_START:
  - On ps2_clk_negedge with ps2_data = 0 -> DATA_IN, bit counter = 0.
  - On ps2_clk_negedge with ps2_data = 1: stay in WAIT_FOR_START, no flag.
- DATA_IN:
  - Each ps2_clk_negedge samples ps2_data into bit[counter], LSB first, and increments the counter.
  - After the 8th sample (counter was 7) -> PARITY_IN.
- PARITY_IN: next ps2_clk_negedge latches the parity bit -> STOP_IN.
- STOP_IN: next ps2_clk_negedge samples the stop bit, then evaluates in the following priority order:
  - Parity check: if XOR of the 8 data bits and the parity bit = 0, pulse error_parity.
  - Otherwise, if stop = 0, pulse error_framing.
  - Otherwise, load received_data and pulse received_data_en.
  - Only one of the three pulses fires per frame.
- Latency: the selected pulse (and received_data on success) is asserted in the cycle after the cycle in which the stop-bit ps2_clk_negedge is seen.
- received_data is unchanged on any error.
- After frame end: -> WAIT_FOR_START if receive_enable = 1, else IDLE.
- busy: 1 in DATA_IN, PARITY_IN and STOP_IN; 0 otherwise.
- ps2_clk_posedge: ignored for sampling. It does not reset the timeout.
- Timeout counter:
  - Cleared on entry to DATA_IN.
  - Increments each clk in DATA_IN, PARITY_IN and STOP_IN, saturating at CLOCK_CYCLES_FOR_2MS.
  - On reaching CLOCK_CYCLES_FOR_2MS: pulse error_timeout, discard the partial frame, go to WAIT_FOR_START if enabled, else IDLE.
  - Held at 0 in IDLE and WAIT_FOR_START.
- Simultaneous timeout and the stop-bit negedge in the same cycle: the negedge wins (frame evaluated normally, no error_timeout).
- receive_enable deasserted mid-frame: next cycle state = IDLE, partial frame discarded, counters cleared, no pulses, received_data retained.
- receive_enable deasserted in the same cycle as the stop-bit negedge: abort wins, no pulse.
- Strobes and errors never assert with busy = 0, except the single end-of-frame cycle.
- Counter widths:
  - bit counter 3 bits (wraps unused).
  - timeout counter NUMBER_OF_BITS_FOR_2MS bits.

Test Plan:
- Good byte: receive_enable = 1; frame start 0, data 0,1,0,1,1,1,1,1, parity 1, stop 1, with negedge strobes every 5000 clk -> received_data = 0xFA, received_data_en high for exactly one cycle after the 11th negedge, no error pulses, busy falls the same cycle.
- Parity error: byte 0xAA sent with parity 0 -> error_parity single pulse; received_data keeps its previous value (0xFA); received_data_en stays 0.
- Framing error: byte 0x55 with correct parity 1 and stop 0 -> error_framing single pulse, no received_data_en. A following good frame 0x12 (parity 1) -> received_data = 0x12.
- Timeout: start bit plus 3 data negedges, then no strobes -> error_timeout pulses exactly 200000 clk after DATA_IN entry; busy drops. A subsequent frame 0xF0 is received correctly.
- Abort: drop receive_enable after 4 data bits -> state IDLE next cycle, no pulses. Re-enable and send 0x3C -> received_data = 0x3C.
- Reset mid-frame: assert reset_n low asynchronously between strobes during PARITY_IN -> all outputs 0 immediately, received_data = 0x00. After release, frame 0xED (parity 1) is received correctly.

Source files
------------

// File: rtl/ps2_data_in.sv
// ps2_data_in: PS/2 device-to-host frame receiver with parity, stop-bit and frame-timeout checking
module ps2_data_in #(
  parameter int CLOCK_CYCLES_FOR_2MS   = 200000,
  parameter int NUMBER_OF_BITS_FOR_2MS = 18
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       receive_enable,
  input  logic       ps2_clk_posedge,
  input  logic       ps2_clk_negedge,
  input  logic       ps2_data,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       error_parity,
  output logic       error_framing,
  output logic       error_timeout,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, WAIT_FOR_START, DATA_IN, PARITY_IN, STOP_IN} state_t;
  localparam logic [NUMBER_OF_BITS_FOR_2MS-1:0] tmo_max  = NUMBER_OF_BITS_FOR_2MS'(CLOCK_CYCLES_FOR_2MS);
  localparam logic [NUMBER_OF_BITS_FOR_2MS-1:0] tmo_last = NUMBER_OF_BITS_FOR_2MS'(CLOCK_CYCLES_FOR_2MS - 1);
  state_t state, state_nx;
  logic [7:0] shift_reg;
  logic [2:0] bit_cnt;
  logic parity_bit;
  logic [NUMBER_OF_BITS_FOR_2MS-1:0] tmo_cnt;
  logic in_frame, start_seen, frame_end, tmo_hit, parity_ok, unused_posedge;
  assign unused_posedge = ps2_clk_posedge;
  assign in_frame = state == DATA_IN || state == PARITY_IN || state == STOP_IN;
  assign start_seen = state == WAIT_FOR_START && ps2_clk_negedge && !ps2_data;
  assign frame_end = state == STOP_IN && ps2_clk_negedge;
  // the stop-bit edge beats a timeout landing in the same cycle
  assign tmo_hit = in_frame && !frame_end && tmo_cnt >= tmo_last;
  assign parity_ok = ^{shift_reg, parity_bit};
  assign busy = in_frame;
  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end
  // next state: disable aborts everything, frame end or timeout returns to hunting for a start bit
  always_comb begin
    state_nx = state;
    if (!receive_enable) state_nx = IDLE;
    else if (tmo_hit || frame_end) state_nx = WAIT_FOR_START;
    else
      case (state)
        IDLE:           state_nx = WAIT_FOR_START;
        WAIT_FOR_START: state_nx = start_seen ? DATA_IN : WAIT_FOR_START;
        DATA_IN:        state_nx = ps2_clk_negedge && bit_cnt == 3'd7 ? PARITY_IN : DATA_IN;
        PARITY_IN:      state_nx = ps2_clk_negedge ? STOP_IN : PARITY_IN;
        default:        state_nx = state;
      endcase
  end
  // deserialiser, timeout counter and registered end-of-frame pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      bit_cnt <= '0;
      parity_bit <= 1'b0;
      tmo_cnt <= '0;
      received_data <= '0;
      received_data_en <= 1'b0;
      error_parity <= 1'b0;
      error_framing <= 1'b0;
      error_timeout <= 1'b0;
    end else begin
      received_data_en <= 1'b0;
      error_parity <= 1'b0;
      error_framing <= 1'b0;
      error_timeout <= 1'b0;
      if (!receive_enable) begin
        shift_reg <= '0;
        bit_cnt <= '0;
        parity_bit <= 1'b0;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= !in_frame || tmo_hit || frame_end ? '0 : tmo_cnt == tmo_max ? tmo_cnt : tmo_cnt + 1'b1;
        error_timeout <= tmo_hit;
        if (start_seen) bit_cnt <= '0;
        if (state == DATA_IN && ps2_clk_negedge) begin
          shift_reg[bit_cnt] <= ps2_data;
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (state == PARITY_IN && ps2_clk_negedge) parity_bit <= ps2_data;
        if (frame_end) begin
          error_parity <= !parity_ok;
          error_framing <= parity_ok && !ps2_data;
          received_data_en <= parity_ok && ps2_data;
          if (parity_ok && ps2_data) received_data <= shift_reg;
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_data_in.sv
// tb_ps2_data_in: randomized frame stimulus with a queued reference model and an independent output monitor
module tb_ps2_data_in;
  localparam int TMO = 1000;
  localparam logic [3:0] K_GOOD = 4'b1000, K_PAR = 4'b0100, K_FRM = 4'b0010, K_TMO = 4'b0001;
  logic clk = 0, reset_n = 0, receive_enable = 0, ps2_clk_posedge = 0, ps2_clk_negedge = 0, ps2_data = 1;
  logic [7:0] received_data;
  logic received_data_en, error_parity, error_framing, error_timeout, busy;
  typedef struct {logic [3:0] kind; logic [7:0] rdata; int cycle;} ev_t;
  ev_t q[$];
  int cyc = 0, compared = 0, mismatched = 0;
  logic [7:0] last_good = 8'h00;

  ps2_data_in #(.CLOCK_CYCLES_FOR_2MS(TMO), .NUMBER_OF_BITS_FOR_2MS(18)) dut (
    .clk(clk), .reset_n(reset_n), .receive_enable(receive_enable),
    .ps2_clk_posedge(ps2_clk_posedge), .ps2_clk_negedge(ps2_clk_negedge), .ps2_data(ps2_data),
    .received_data(received_data), .received_data_en(received_data_en), .error_parity(error_parity),
    .error_framing(error_framing), .error_timeout(error_timeout), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    ps2_clk_negedge = 1;
    tick();
    ps2_clk_negedge = 0;
    ps2_data = 1'($urandom_range(0, 1));
    repeat ($urandom_range(1, 6)) begin
      ps2_clk_posedge = $urandom_range(0, 3) == 0;
      tick();
    end
    ps2_clk_posedge = 0;
    ps2_data = 1;
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  // stop_at > 0 places the stop-bit edge on that absolute cycle; abort drops enable with the stop edge
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input logic abort, input int stop_at);
    ev_t e;
    send_bit(0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    while (stop_at > 0 && cyc + 1 < stop_at) tick();
    if (($countones(d) + int'(par)) % 2 == 0) e.kind = K_PAR;
    else if (!stop) e.kind = K_FRM;
    else e.kind = K_GOOD;
    if (abort) receive_enable = 0;
    else begin
      if (e.kind == K_GOOD) last_good = d;
      e.rdata = last_good;
      e.cycle = cyc + 1;
      q.push_back(e);
    end
    send_bit(stop);
    if (abort) begin
      chk("abort_at_stop_busy", busy, 0);
      receive_enable = 1;
      tick();
    end
  endtask

  // monitor: every pulse must match the oldest expected event, with its cycle and retained data
  always @(negedge clk) begin
    logic [3:0] p;
    ev_t e;
    p = {received_data_en, error_parity, error_framing, error_timeout};
    if (p != 4'b0) begin
      if (q.size() == 0) chk("unexpected_pulse", 32'(p), 0);
      else begin
        e = q.pop_front();
        chk("pulse_kind", 32'(p), 32'(e.kind));
        chk("pulse_cycle", cyc, e.cycle);
        chk("rx_data", 32'(received_data), 32'(e.rdata));
        chk("busy_at_end", 32'(busy), 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_t e;
    int s;
    logic [7:0] d;
    repeat (3) tick();
    chk("reset_rx_data", 32'(received_data), 0);
    chk("reset_rx_en", 32'(received_data_en), 0);
    chk("reset_err_parity", 32'(error_parity), 0);
    chk("reset_err_framing", 32'(error_framing), 0);
    chk("reset_err_timeout", 32'(error_timeout), 0);
    chk("reset_busy", 32'(busy), 0);
    reset_n = 1;
    tick();
    receive_enable = 1;
    tick();
    send_bit(1);
    send_bit(1);
    chk("idle_high_no_start", 32'(busy), 0);
    send_frame(8'hFA, 1, 1, 0, 0);
    send_frame(8'hAA, 0, 1, 0, 0);
    send_frame(8'h55, 1, 0, 0, 0);
    send_frame(8'h12, 1, 1, 0, 0);
    s = cyc + 1;
    e.kind = K_TMO;
    e.rdata = last_good;
    e.cycle = s + TMO;
    q.push_back(e);
    send_bit(0);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    chk("busy_mid_frame", 32'(busy), 1);
    repeat (TMO + 10) tick();
    chk("busy_after_timeout", 32'(busy), 0);
    send_frame(8'hF0, 1, 1, 0, 0);
    send_bit(0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    receive_enable = 0;
    tick();
    chk("abort_busy", 32'(busy), 0);
    repeat (3) tick();
    receive_enable = 1;
    tick();
    send_frame(8'h3C, 1, 1, 0, 0);
    send_frame(8'h81, 1, 1, 1, 0);
    s = cyc + 1;
    send_frame(8'h69, good_par(8'h69), 1, 0, s + TMO);
    send_bit(0);
    for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
    #2 reset_n = 0;
    #1;
    chk("async_rst_rx_data", 32'(received_data), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_pulses", 32'({received_data_en, error_parity, error_framing, error_timeout}), 0);
    last_good = 8'h00;
    repeat (2) tick();
    reset_n = 1;
    tick();
    tick();
    send_frame(8'hED, 1, 1, 0, 0);
    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 4) == 0) send_bit(1);
      send_frame(d, $urandom_range(0, 4) == 0 ? !good_par(d) : good_par(d), $urandom_range(0, 5) != 0, 0, 0);
    end
    for (int i = 0; i < 100 && q.size() != 0; i++) tick();
    chk("drain_queue", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
